heap_arbiter: RTL and testbench
===============================

// Module: heap_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer sharing one array Memory (heap) between REQUESTERS clients.
//  Accepts one array operation per grant and drives the heap action/array/index/data lines.
//  Steps the heap by toggling heap_step (the heap acts on every transition of its clock input).
//  Captures heap_out after a fixed settle time and returns it to the granted client.
//  Sits between program engines in fpga and the heap Memory instance.
// PARAMETERS
//  REQUESTERS    4   number of clients; 2..8
//  ADDRESS_BITS  2   heap array-number width
//  INDEX_BITS    1   heap element-index width
//  DATA_BITS    12   heap data width
//  SETTLE        1   clock cycles from heap_step toggle to heap_out sample; 1..7
// PORTS
//  clock        in   1                        single clock, rising edge
//  reset        in   1                        asynchronous, active-high
//  req_valid    in   REQUESTERS               client i has an operation pending
//  req_ready    out  REQUESTERS               one-hot grant; op accepted when valid&ready
//  req_action   in   REQUESTERS*8             per-client action code, client i at [8i+:8]
//  req_array    in   REQUESTERS*ADDRESS_BITS  per-client array number
//  req_index    in   REQUESTERS*INDEX_BITS    per-client element index
//  req_data     in   REQUESTERS*DATA_BITS     per-client write/compare data
//  resp_valid   out  REQUESTERS               one-hot: result for client i on resp_data
//  resp_ready   in   REQUESTERS               client i takes result when valid&ready
//  resp_data    out  DATA_BITS                captured heap_out
//  resp_error   out  1                        action code unsupported; resp_data = 0
//  heap_step    out  1                        toggles once per heap operation
//  heap_action  out  8                        to heap action
//  heap_array   out  ADDRESS_BITS             to heap array
//  heap_index   out  INDEX_BITS               to heap index
//  heap_in      out  DATA_BITS                to heap input data
//  heap_out     in   DATA_BITS                from heap out
//  busy         out  1                        high in any state except IDLE
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, all outputs 0; heap_step 0; other heap_* 0.
//  States:
//   IDLE    no grant; on any req_valid -> GRANT.
//   GRANT   req_ready one-hot for 1 cycle to winner; latch its fields.
//           Unsupported action -> RESP with resp_error=1. Else -> ISSUE.
//   ISSUE   heap_* drive latched fields; heap_step toggles on entry; counter=SETTLE -> WAIT.
//   WAIT    counter decrements each cycle; at 0 latch resp_data<=heap_out -> RESP.
//   RESP    resp_valid[winner]=1, data stable; hold until resp_ready[winner].
//           On handshake: next requester pending -> GRANT, else IDLE.
//  Latency: request seen in IDLE -> resp_valid after 3+SETTLE cycles (SETTLE=1: 4).
//  Round robin: winner = first valid at or after pointer, wrapping; pointer <= winner+1 mod REQUESTERS.
//  Client dropping req_valid before grant is legal; no grant goes to it.
//  heap_* hold last values after an op; heap_step changes only on ISSUE entry.
//  Reset mid-op: abort; no response; heap_step returns to 0 (may count as one extra heap step; harmless for reads).
//  resp_ready to a non-winner is ignored. One op in flight; no pipelining.
// STRUCTURE
//  Package heap_pkg:
//   action codes ACT_SIZE=8'd4, ACT_GREATER=8'd9;
//   function act_supported(action) true for both codes;
//   typedef enum logic[2:0] {IDLE,GRANT,ISSUE,WAIT,RESP} heap_arb_state_t.
//  Sub-module rr_arbiter #(N): pure combinational; ports valid[N], pointer, grant one-hot.
//  heap_arbiter owns the pointer register and the FSM.
// TESTING  (REQUESTERS=4, SETTLE=1, heap model behind heap_* ports)
//  Single req client 2, Size of array 1 (size 1)
//   -> req_ready[2] one pulse; heap_step toggles once; resp_valid[2] 4 cycles later; resp_data=1.
//  Clients 0,1,3 all valid and held
//   -> grants in order 0,1,3,0; each grant only after the previous resp handshake.
//  req_action=8'd7 from client 1
//   -> resp_error=1, resp_data=0, no heap_step toggle.
//  resp_ready[0] held low 5 cycles
//   -> resp_valid[0], resp_data stable throughout; no new grant until accepted.
//  reset asserted in WAIT
//   -> next cycle all outputs 0, state IDLE; no resp_valid; heap_step=0.
//  Greater on array 0, size 1
//   -> resp_data=1; busy high from GRANT through the RESP handshake.

Source files
------------

// File: rtl/heap_pkg.sv
// Shared action codes, the support check and the sequencer state type for heap_arbiter.
package heap_pkg;

   localparam logic [7:0] ACT_SIZE    = 8'd4;
   localparam logic [7:0] ACT_GREATER = 8'd9;

   function automatic logic act_supported(input logic [7:0] action);
      return (action == ACT_SIZE) || (action == ACT_GREATER);
   endfunction

   typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT, RESP} heap_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid at or after pointer_i, wrapping, one-hot grant.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         valid_i,
   input  logic [$clog2(N)-1:0] pointer_i,
   output logic [N-1:0]         grant_o
);

   localparam int unsigned PW = $clog2(N);

   always_comb begin
      int unsigned slot;
      logic        found;
      grant_o = '0;
      found   = 1'b0;
      slot    = 0;
      for (int unsigned k = 0; k < N; k++) begin
         slot = (32'(pointer_i) + k) % N;
         if (!found && valid_i[slot[PW-1:0]]) begin
            grant_o[slot[PW-1:0]] = 1'b1;
            found                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/heap_arbiter.sv
// Round-robin sequencer sharing one heap memory between REQUESTERS clients, one op in flight.
module heap_arbiter
   import heap_pkg::*;
#(
   parameter int unsigned REQUESTERS   = 4,
   parameter int unsigned ADDRESS_BITS = 2,
   parameter int unsigned INDEX_BITS   = 1,
   parameter int unsigned DATA_BITS    = 12,
   parameter int unsigned SETTLE       = 1
) (
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic [REQUESTERS-1:0]              req_valid_i,
   output logic [REQUESTERS-1:0]              req_ready_o,
   input  logic [REQUESTERS*8-1:0]            req_action_i,
   input  logic [REQUESTERS*ADDRESS_BITS-1:0] req_array_i,
   input  logic [REQUESTERS*INDEX_BITS-1:0]   req_index_i,
   input  logic [REQUESTERS*DATA_BITS-1:0]    req_data_i,
   output logic [REQUESTERS-1:0]              resp_valid_o,
   input  logic [REQUESTERS-1:0]              resp_ready_i,
   output logic [DATA_BITS-1:0]               resp_data_o,
   output logic                               resp_error_o,
   output logic                               heap_step_o,
   output logic [7:0]                         heap_action_o,
   output logic [ADDRESS_BITS-1:0]            heap_array_o,
   output logic [INDEX_BITS-1:0]              heap_index_o,
   output logic [DATA_BITS-1:0]               heap_in_o,
   input  logic [DATA_BITS-1:0]               heap_out_i,
   output logic                               busy_o
);

   localparam int unsigned PW = $clog2(REQUESTERS);

   heap_arb_state_t         state_q;
   logic [PW-1:0]           ptr_q, win_q, arb_idx, ptr_next;
   logic [REQUESTERS-1:0]   arb_grant, win_onehot;
   logic [REQUESTERS-1:0]   req_ready_q, resp_valid_q;
   logic [DATA_BITS-1:0]    resp_data_q, heap_in_q;
   logic                    resp_error_q, heap_step_q;
   logic [7:0]              heap_action_q, win_action;
   logic [ADDRESS_BITS-1:0] heap_array_q, win_array;
   logic [INDEX_BITS-1:0]   heap_index_q, win_index;
   logic [DATA_BITS-1:0]    win_data;
   logic [2:0]              cnt_q;

   rr_arbiter #(
      .N (REQUESTERS)
   ) u_rr_arbiter (
      .valid_i   (req_valid_i),
      .pointer_i (ptr_q),
      .grant_o   (arb_grant)
   );

   always_comb begin
      arb_idx = '0;
      for (int unsigned i = 0; i < REQUESTERS; i++) begin
         if (arb_grant[i]) arb_idx = PW'(i);
      end
      win_action = req_action_i[8*win_q +: 8];
      win_array  = req_array_i[ADDRESS_BITS*win_q +: ADDRESS_BITS];
      win_index  = req_index_i[INDEX_BITS*win_q +: INDEX_BITS];
      win_data   = req_data_i[DATA_BITS*win_q +: DATA_BITS];
      win_onehot = {{(REQUESTERS-1){1'b0}}, 1'b1} << win_q;
      ptr_next   = (32'(win_q) == REQUESTERS - 1) ? '0 : win_q + 1'b1;
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         win_q         <= '0;
         req_ready_q   <= '0;
         resp_valid_q  <= '0;
         resp_data_q   <= '0;
         resp_error_q  <= 1'b0;
         heap_step_q   <= 1'b0;
         heap_action_q <= '0;
         heap_array_q  <= '0;
         heap_index_q  <= '0;
         heap_in_q     <= '0;
         cnt_q         <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|req_valid_i) begin
                  win_q       <= arb_idx;
                  req_ready_q <= arb_grant;
                  state_q     <= GRANT;
               end
            end
            GRANT: begin
               req_ready_q <= '0;
               // A client that withdrew during its grant cycle is simply skipped.
               if (req_valid_i[win_q]) begin
                  ptr_q <= ptr_next;
                  if (act_supported(win_action)) begin
                     heap_action_q <= win_action;
                     heap_array_q  <= win_array;
                     heap_index_q  <= win_index;
                     heap_in_q     <= win_data;
                     heap_step_q   <= ~heap_step_q;
                     state_q       <= ISSUE;
                  end else begin
                     resp_error_q <= 1'b1;
                     resp_data_q  <= '0;
                     resp_valid_q <= win_onehot;
                     state_q      <= RESP;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            ISSUE: begin
               cnt_q   <= 3'(SETTLE);
               state_q <= WAIT;
            end
            WAIT: begin
               cnt_q <= cnt_q - 3'd1;
               if (cnt_q <= 3'd1) begin
                  resp_data_q  <= heap_out_i;
                  resp_error_q <= 1'b0;
                  resp_valid_q <= win_onehot;
                  state_q      <= RESP;
               end
            end
            RESP: begin
               if (resp_ready_i[win_q]) begin
                  resp_valid_q <= '0;
                  resp_error_q <= 1'b0;
                  if (|req_valid_i) begin
                     win_q       <= arb_idx;
                     req_ready_q <= arb_grant;
                     state_q     <= GRANT;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o   = req_ready_q;
   assign resp_valid_o  = resp_valid_q;
   assign resp_data_o   = resp_data_q;
   assign resp_error_o  = resp_error_q;
   assign heap_step_o   = heap_step_q;
   assign heap_action_o = heap_action_q;
   assign heap_array_o  = heap_array_q;
   assign heap_index_o  = heap_index_q;
   assign heap_in_o     = heap_in_q;
   assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_heap_arbiter.sv
// Bench for heap_arbiter: directed scenarios plus random traffic against a round-robin/heap model.
module tb_heap_arbiter;
   import heap_pkg::*;

   localparam int unsigned N      = 4;
   localparam int unsigned AB     = 2;
   localparam int unsigned IB     = 1;
   localparam int unsigned DB     = 12;
   localparam int unsigned SETTLE = 1;

   logic              clock = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid, req_ready, resp_valid, resp_ready;
   logic [N*8-1:0]    req_action;
   logic [N*AB-1:0]   req_array;
   logic [N*IB-1:0]   req_index;
   logic [N*DB-1:0]   req_data;
   logic [DB-1:0]     resp_data, heap_in, heap_out;
   logic              resp_error, heap_step, busy;
   logic [7:0]        heap_action;
   logic [AB-1:0]     heap_array;
   logic [IB-1:0]     heap_index;

   always #5 clock = ~clock;

   heap_arbiter #(
      .REQUESTERS   (N),
      .ADDRESS_BITS (AB),
      .INDEX_BITS   (IB),
      .DATA_BITS    (DB),
      .SETTLE       (SETTLE)
   ) dut (
      .clock_i       (clock),
      .reset_i       (reset),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_action_i  (req_action),
      .req_array_i   (req_array),
      .req_index_i   (req_index),
      .req_data_i    (req_data),
      .resp_valid_o  (resp_valid),
      .resp_ready_i  (resp_ready),
      .resp_data_o   (resp_data),
      .resp_error_o  (resp_error),
      .heap_step_o   (heap_step),
      .heap_action_o (heap_action),
      .heap_array_o  (heap_array),
      .heap_index_o  (heap_index),
      .heap_in_o     (heap_in),
      .heap_out_i    (heap_out),
      .busy_o        (busy)
   );

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Heap memory model: array sizes; Size returns the size, Greater returns size > data.
   logic [DB-1:0] sizes [N];

   function automatic logic [DB-1:0] heap_eval(input logic [7:0] act, input logic [AB-1:0] arr,
                                                input logic [DB-1:0] d);
      if (act == 8'd4) return sizes[arr];
      if (act == 8'd9) return (sizes[arr] > d) ? DB'(1) : DB'(0);
      return DB'(12'hABC);
   endfunction

   initial heap_out = '0;
   always begin
      @(heap_step);
      #1 heap_out = heap_eval(heap_action, heap_array, heap_in);
   end

   function automatic logic [N-1:0] onehot(input int unsigned i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Reference monitor, sampled on the falling edge.
   int          cyc = 0;
   bit          in_flight, m_resp_seen, m_err, idle_pending;
   int unsigned m_ptr, m_win;
   int          resp_due, steps_op;
   logic [DB-1:0] m_data;
   logic        last_step;
   int unsigned grants_q[$];

   always @(negedge clock) begin
      cyc++;
      if (reset) begin
         in_flight    = 0;
         m_resp_seen  = 0;
         m_ptr        = 0;
         idle_pending = 0;
         last_step    = heap_step;
      end else begin
         if (in_flight && m_resp_seen) begin
            if (resp_ready[m_win]) begin
               check_eq("resp_clear", 32'(resp_valid), 0);
               in_flight = 0;
            end else begin
               check_eq("resp_hold", 32'(resp_valid), 32'(onehot(m_win)));
               check_eq("resp_stable", 32'(resp_data), 32'(m_data));
               check_eq("err_stable", 32'(resp_error), 32'(m_err));
            end
         end else if (in_flight) begin
            if (cyc == resp_due) begin
               check_eq("resp_valid", 32'(resp_valid), 32'(onehot(m_win)));
               check_eq("resp_data", 32'(resp_data), 32'(m_data));
               check_eq("resp_error", 32'(resp_error), 32'(m_err));
               check_eq("steps_per_op", steps_op, m_err ? 0 : 1);
               m_resp_seen = 1;
            end else begin
               check_eq("resp_early", 32'(resp_valid), 0);
            end
         end
         if (heap_step !== last_step) begin
            steps_op++;
            check_eq("step_in_op", 32'(in_flight), 1);
            last_step = heap_step;
         end
         if (idle_pending) check_eq("grant_seen", 32'(|req_ready), 1);
         if (req_ready != '0) begin
            int unsigned w;
            logic [7:0]  act;
            w = 0;
            for (int k = N - 1; k >= 0; k--) begin
               if (req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            check_eq("grant_excl", 32'(in_flight), 0);
            check_eq("grant", 32'(req_ready), 32'(onehot(w)));
            grants_q.push_back(w);
            act         = req_action[8*w +: 8];
            m_err       = !(act == 8'd4 || act == 8'd9);
            m_data      = m_err ? '0 : heap_eval(act, req_array[AB*w +: AB], req_data[DB*w +: DB]);
            m_ptr       = (w + 1) % N;
            m_win       = w;
            in_flight   = 1;
            m_resp_seen = 0;
            steps_op    = 0;
            resp_due    = cyc + (m_err ? 1 : 2 + SETTLE);
         end
         check_eq("busy", 32'(busy), 32'(in_flight));
         idle_pending = !in_flight && (req_valid != '0);
      end
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic drive_op(input int unsigned c, input logic [7:0] act, input logic [AB-1:0] arr,
                           input logic [DB-1:0] d);
      req_action[8*c +: 8]   = act;
      req_array[AB*c +: AB]  = arr;
      req_index[IB*c +: IB]  = IB'($urandom_range(0, 1));
      req_data[DB*c +: DB]   = d;
      req_valid[c]           = 1'b1;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      req_valid  = '0;
      resp_ready = '0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic check_outs_zero(input string tag);
      check_eq({tag, "_ctl"}, {req_ready, resp_valid, resp_error, heap_step, busy, heap_action}, 0);
      check_eq({tag, "_dat"}, {resp_data, heap_in, heap_array, heap_index}, 0);
   endtask

   // One client, one op; waits for the response, then accepts it after `hold` cycles.
   task automatic single_op(input int unsigned c, input logic [7:0] act, input logic [AB-1:0] arr,
                            input logic [DB-1:0] d, input int hold, output int lat,
                            output logic [DB-1:0] data, output logic err);
      bit granted;
      granted = 0;
      lat     = -1;
      data    = '0;
      err     = 1'b0;
      tick();
      drive_op(c, act, arr, d);
      for (int k = 1; k <= 20 && lat < 0; k++) begin
         @(negedge clock);
         if (resp_valid[c]) begin
            lat  = k;
            data = resp_data;
            err  = resp_error;
         end
         #1;
         if (granted) req_valid[c] = 1'b0;
         if (req_ready[c]) granted = 1;
      end
      if (lat < 0) check_eq("resp_timeout", 0, 1);
      repeat (hold) tick();
      resp_ready[c] = 1'b1;
      tick();
      resp_ready[c] = 1'b0;
      req_valid[c]  = 1'b0;
   endtask

   task automatic run_random(input int cycles, input bit gen);
      bit granted [N];
      for (int i = 0; i < N; i++) granted[i] = 0;
      for (int t = 0; t < cycles; t++) begin
         tick();
         for (int unsigned i = 0; i < N; i++) begin
            if (granted[i]) begin
               req_valid[i] = 1'b0;
               granted[i]   = 0;
            end else if (req_ready[i]) begin
               granted[i] = 1;
            end else if (gen && !req_valid[i] && $urandom_range(0, 3) == 0) begin
               int unsigned r;
               logic [7:0]  act;
               r   = $urandom_range(0, 9);
               act = (r < 4) ? 8'd4 : (r < 8) ? 8'd9 : 8'($urandom_range(0, 255));
               drive_op(i, act, AB'($urandom_range(0, N - 1)), DB'($urandom_range(0, 4)));
            end
         end
         resp_ready = gen ? N'($urandom_range(0, 15)) : '1;
      end
   endtask

   initial begin
      int            lat;
      logic [DB-1:0] data;
      logic          err, step0;
      sizes[0]   = 1;
      sizes[1]   = 1;
      sizes[2]   = 2;
      sizes[3]   = 3;
      req_action = '0;
      req_array  = '0;
      req_index  = '0;
      req_data   = '0;
      reset      = 1'b1;
      req_valid  = '0;
      resp_ready = '0;
      repeat (2) tick();
      check_outs_zero("reset");
      reset = 1'b0;
      tick();

      // Client 2 reads the size of array 1.
      step0 = heap_step;
      single_op(2, ACT_SIZE, 1, 0, 0, lat, data, err);
      check_eq("a_latency", lat, 3 + SETTLE);
      check_eq("a_data", 32'(data), 1);
      check_eq("a_step", 32'(heap_step), 32'(!step0));
      check_eq("a_hold_action", 32'(heap_action), 4);
      check_eq("a_hold_array", 32'(heap_array), 1);

      // Unsupported action from client 1.
      step0 = heap_step;
      single_op(1, 8'd7, 2, 5, 0, lat, data, err);
      check_eq("c_error", 32'(err), 1);
      check_eq("c_data", 32'(data), 0);
      check_eq("c_nostep", 32'(heap_step), 32'(step0));
      check_eq("c_hold_action", 32'(heap_action), 4);

      // Clients 0, 1 and 3 valid and held from a fresh pointer.
      do_reset();
      grants_q.delete();
      drive_op(0, ACT_SIZE, 0, 0);
      drive_op(1, ACT_SIZE, 1, 0);
      drive_op(3, ACT_SIZE, 3, 0);
      resp_ready = '1;
      for (int k = 0; k < 60 && grants_q.size() < 4; k++) tick();
      tick();
      req_valid = '0;
      for (int k = 0; k < 20 && busy; k++) tick();
      check_eq("b_drain", 32'(busy), 0);
      resp_ready = '0;
      check_eq("b_count", grants_q.size() >= 4 ? 4 : grants_q.size(), 4);
      if (grants_q.size() >= 4) begin
         check_eq("b_order0", grants_q[0], 0);
         check_eq("b_order1", grants_q[1], 1);
         check_eq("b_order2", grants_q[2], 3);
         check_eq("b_order3", grants_q[3], 0);
      end

      // Response held off for five cycles.
      single_op(0, ACT_SIZE, 3, 0, 5, lat, data, err);
      check_eq("d_data", 32'(data), 3);

      // Greater on array 0 of size 1.
      single_op(3, ACT_GREATER, 0, 0, 1, lat, data, err);
      check_eq("f_data", 32'(data), 1);
      check_eq("f_error", 32'(err), 0);

      // Reset while waiting on the heap.
      tick();
      drive_op(1, ACT_SIZE, 2, 0);
      repeat (3) tick();
      check_eq("e_busy_wait", 32'(busy), 1);
      reset = 1'b1;
      @(negedge clock);
      check_outs_zero("e_reset");
      #1;
      req_valid = '0;
      reset     = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         check_eq("e_no_resp", 32'(resp_valid), 0);
      end

      // Random traffic, then drain.
      for (int i = 0; i < N; i++) sizes[i] = DB'($urandom_range(0, 4));
      run_random(3000, 1'b1);
      run_random(100, 1'b0);
      check_eq("final_idle", {busy, req_valid, resp_valid}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
